// File: rtl/dma_dsc_cache_mc_if.sv
// Push/pop/output handshake bundle for the multi-channel descriptor cache.
// Signal names match the original flat port list for drop-in compatibility.
interface dma_dsc_cache_mc_if #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  parameter int NUM_CH = 2
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = $clog2(DEPTH);

  logic                        W_VALID;
  logic [CH_W-1:0]             W_CH;
  logic [DATA_W-1:0]           W_DATA;
  logic                        W_READY;
  logic                        RD_REQ;
  logic [CH_W-1:0]             RD_CH;
  logic                        RD_ACK;
  logic                        R_VALID;
  logic                        R_READY;
  logic [DATA_W-1:0]           R_DATA;
  logic [CH_W-1:0]             R_CHO;
  logic [NUM_CH-1:0]           FLUSH;
  logic [NUM_CH-1:0]           EMPTY;
  logic [NUM_CH-1:0]           FULL;
  logic [NUM_CH*(PTR_W+1)-1:0] LEVEL;

  modport master (
    output W_VALID, W_CH, W_DATA, RD_REQ, RD_CH, R_READY, FLUSH,
    input  W_READY, RD_ACK, R_VALID, R_DATA, R_CHO, EMPTY, FULL, LEVEL
  );

  modport slave (
    input  W_VALID, W_CH, W_DATA, RD_REQ, RD_CH, R_READY, FLUSH,
    output W_READY, RD_ACK, R_VALID, R_DATA, R_CHO, EMPTY, FULL, LEVEL
  );
endinterface

// File: rtl/dma_dsc_cache_mc.sv
// Multi-channel descriptor cache: per-channel circular FIFOs in one shared RAM,
// 2-cycle registered read path feeding a 2-entry skid buffer with credit gating.
module dma_dsc_cache_mc #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  parameter int NUM_CH = 2
) (
  input  logic              CLK,
  input  logic              RESETN,
  dma_dsc_cache_mc_if.slave bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int AW    = CH_W + PTR_W;
  localparam int LW    = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr [NUM_CH];
  logic [LW-1:0]     level  [NUM_CH];
  logic [DATA_W-1:0] mem    [NUM_CH*DEPTH];

  logic [NUM_CH-1:0] empty, full, push_v, pop_v;
  logic              w_ready, w_fire, rd_ok, rd_ack, r_fire;
  logic [PTR_W-1:0]  wr_ptr_sel, rd_ptr_sel;
  logic [1:0]        in_use;

  logic              rd_pend;
  logic [AW-1:0]     rd_addr_q;
  logic [CH_W-1:0]   rd_ch_q;

  logic [DATA_W-1:0] skid_data [2];
  logic [CH_W-1:0]   skid_ch   [2];
  logic              skid_head, skid_tail;
  logic [1:0]        skid_cnt;

  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      empty[c] = (level[c] == '0);
      full[c]  = (level[c] == LW'(DEPTH));
    end
  end

  // Channel decode by compare rather than indexing so out-of-range channels
  // simply match nothing and are refused.
  always_comb begin
    w_ready    = 1'b0;
    rd_ok      = 1'b0;
    wr_ptr_sel = '0;
    rd_ptr_sel = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (bus.W_CH == CH_W'(c)) begin
        w_ready    = !full[c] && !bus.FLUSH[c];
        wr_ptr_sel = wr_ptr[c];
      end
      if (bus.RD_CH == CH_W'(c)) begin
        rd_ok      = !empty[c] && !bus.FLUSH[c];
        rd_ptr_sel = rd_ptr[c];
      end
    end
  end

  assign in_use = {1'b0, rd_pend} + skid_cnt;
  assign w_fire = bus.W_VALID && w_ready;
  assign rd_ack = bus.RD_REQ && rd_ok && (in_use < 2'd2);
  assign r_fire = (skid_cnt != 2'd0) && bus.R_READY;

  always_comb begin
    push_v = '0;
    pop_v  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      push_v[c] = w_fire && (bus.W_CH == CH_W'(c));
      pop_v[c]  = rd_ack && (bus.RD_CH == CH_W'(c));
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        level[c]  <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (bus.FLUSH[c]) begin
          wr_ptr[c] <= '0;
          rd_ptr[c] <= '0;
          level[c]  <= '0;
        end else begin
          if (push_v[c]) wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
          if (pop_v[c])  rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
          if (push_v[c] && !pop_v[c])      level[c] <= level[c] + LW'(1);
          else if (!push_v[c] && pop_v[c]) level[c] <= level[c] - LW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_fire) mem[{bus.W_CH, wr_ptr_sel}] <= bus.W_DATA;
  end

  // Address registered on the ack cycle, RAM data lands directly in the skid
  // one cycle later; the credit check keeps the skid from ever overflowing.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      rd_pend   <= 1'b0;
      rd_addr_q <= '0;
      rd_ch_q   <= '0;
      skid_head <= 1'b0;
      skid_tail <= 1'b0;
      skid_cnt  <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        skid_data[i] <= '0;
        skid_ch[i]   <= '0;
      end
    end else begin
      rd_pend <= rd_ack;
      if (rd_ack) begin
        rd_addr_q <= {bus.RD_CH, rd_ptr_sel};
        rd_ch_q   <= bus.RD_CH;
      end
      if (rd_pend) begin
        skid_data[skid_tail] <= mem[rd_addr_q];
        skid_ch[skid_tail]   <= rd_ch_q;
        skid_tail            <= ~skid_tail;
      end
      if (r_fire) skid_head <= ~skid_head;
      case ({rd_pend, r_fire})
        2'b10:   skid_cnt <= skid_cnt + 2'd1;
        2'b01:   skid_cnt <= skid_cnt - 2'd1;
        default: skid_cnt <= skid_cnt;
      endcase
    end
  end

  always_comb begin
    bus.LEVEL = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      bus.LEVEL[c*LW +: LW] = level[c];
    end
  end

  assign bus.W_READY = w_ready;
  assign bus.RD_ACK  = rd_ack;
  assign bus.R_VALID = (skid_cnt != 2'd0);
  assign bus.R_DATA  = skid_data[skid_head];
  assign bus.R_CHO   = skid_ch[skid_head];
  assign bus.EMPTY   = empty;
  assign bus.FULL    = full;
endmodule

// File: tb/tb_dma_dsc_cache_mc.sv
// Scoreboard bench for dma_dsc_cache_mc: directed push/pop/flush/reset vectors,
// expected descriptors queued at pop issue and checked by an output monitor.
module tb_dma_dsc_cache_mc;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 4;
  localparam int NUM_CH = 2;
  localparam int LW     = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [0:0]  ch;
    logic [63:0] data;
    int          ack_cyc;
    bit          lat;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  dma_dsc_cache_mc_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH)) bus ();

  dma_dsc_cache_mc #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH)) dut (
    .CLK   (clk),
    .RESETN(rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [2:0] lvl(input int ch);
    return bus.LEVEL[ch*LW +: LW];
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.R_VALID && bus.R_READY) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_output: got ch %0d data %0h, required no output", bus.R_CHO, bus.R_DATA);
      end else begin
        mon_e = sb.pop_front();
        chk("r_data", bus.R_DATA, mon_e.data);
        chk("r_cho", 64'(bus.R_CHO), 64'(mon_e.ch));
        if (mon_e.lat) chk("latency", 64'(cyc - mon_e.ack_cyc), 64'd2);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic expect_out(input logic [0:0] ch, input logic [63:0] data, input bit lat);
    exp_t e;
    e.ch = ch; e.data = data; e.ack_cyc = cyc; e.lat = lat;
    sb.push_back(e);
  endtask

  // All tasks start and end at posedge+1.
  task automatic do_push(input logic [0:0] ch, input logic [63:0] data, input bit exp_rdy);
    bus.W_VALID = 1'b1; bus.W_CH = ch; bus.W_DATA = data;
    @(negedge clk);
    chk("w_ready", 64'(bus.W_READY), 64'(exp_rdy));
    @(posedge clk); #1;
    bus.W_VALID = 1'b0;
  endtask

  task automatic do_pop(input logic [0:0] ch, input logic [63:0] data, input bit lat);
    int waited = 0;
    bit got = 1'b0;
    bus.RD_REQ = 1'b1; bus.RD_CH = ch;
    while (!got && waited < 8) begin
      @(negedge clk);
      if (bus.RD_ACK) begin
        got = 1'b1;
        expect_out(ch, data, lat);
      end
      waited++;
      @(posedge clk); #1;
    end
    bus.RD_REQ = 1'b0;
    chk("rd_ack_within_budget", 64'(got), 64'd1);
  endtask

  task automatic pop_refused(input logic [0:0] ch);
    bus.RD_REQ = 1'b1; bus.RD_CH = ch;
    @(negedge clk);
    chk("rd_ack_refused", 64'(bus.RD_ACK), 64'd0);
    @(posedge clk); #1;
    bus.RD_REQ = 1'b0;
  endtask

  logic [63:0] bv [3];
  int acks;

  initial begin
    rst_n = 1'b0;
    bus.W_VALID = 1'b0; bus.W_CH = '0; bus.W_DATA = '0;
    bus.RD_REQ = 1'b0; bus.RD_CH = '0; bus.R_READY = 1'b1; bus.FLUSH = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // reset state
    chk("reset_empty", 64'(bus.EMPTY), 64'b11);
    chk("reset_full", 64'(bus.FULL), 64'b00);
    chk("reset_level", 64'(bus.LEVEL), 64'd0);
    chk("reset_r_valid", 64'(bus.R_VALID), 64'd0);
    chk("reset_w_ready", 64'(bus.W_READY), 64'd1);
    chk("reset_r_data", bus.R_DATA, 64'd0);
    pop_refused(1'b0);

    // fill ch0
    for (int i = 0; i < 4; i++) do_push(1'b0, 64'hA0 + 64'(i), 1'b1);
    chk("full_ch0", 64'(bus.FULL), 64'b01);
    chk("level_ch0_full", 64'(lvl(0)), 64'd4);
    chk("empty_ch1", 64'(bus.EMPTY), 64'b10);
    do_push(1'b0, 64'hA4, 1'b0);

    // drain ch0 in order, latency 2
    for (int i = 0; i < 4; i++) do_pop(1'b0, 64'hA0 + 64'(i), 1'b1);
    chk("empty_after_drain", 64'(bus.EMPTY), 64'b11);
    repeat (4) @(posedge clk); #1;

    // ch1 interleaved push/pop with pointer wrap
    for (int i = 0; i < 4; i++) do_push(1'b1, 64'hC0 + 64'(i), 1'b1);
    chk("level_ch1_4", 64'(lvl(1)), 64'd4);
    chk("full_ch1", 64'(bus.FULL), 64'b10);
    do_pop(1'b1, 64'hC0, 1'b1);  chk("level_ch1_a", 64'(lvl(1)), 64'd3);
    do_push(1'b1, 64'hC4, 1'b1); chk("level_ch1_b", 64'(lvl(1)), 64'd4);
    do_pop(1'b1, 64'hC1, 1'b1);  chk("level_ch1_c", 64'(lvl(1)), 64'd3);
    do_push(1'b1, 64'hC5, 1'b1); chk("level_ch1_d", 64'(lvl(1)), 64'd4);
    for (int i = 2; i < 6; i++) do_pop(1'b1, 64'hC0 + 64'(i), 1'b1);
    chk("level_ch1_end", 64'(lvl(1)), 64'd0);
    repeat (4) @(posedge clk); #1;

    // backpressure: only two credits
    bv[0] = 64'hB0; bv[1] = 64'hB1; bv[2] = 64'hB2;
    for (int i = 0; i < 3; i++) do_push(1'b0, bv[i], 1'b1);
    bus.R_READY = 1'b0;
    bus.RD_REQ = 1'b1; bus.RD_CH = 1'b0;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.RD_ACK) begin
        if (acks < 3) expect_out(1'b0, bv[acks], 1'b0);
        acks++;
      end
      @(posedge clk); #1;
    end
    chk("acks_under_backpressure", 64'(acks), 64'd2);
    bus.R_READY = 1'b1;
    @(negedge clk);
    chk("no_ack_on_retire_cycle", 64'(bus.RD_ACK), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ack_after_retire", 64'(bus.RD_ACK), 64'd1);
    if (bus.RD_ACK) expect_out(1'b0, bv[2], 1'b0);
    @(posedge clk); #1;
    bus.RD_REQ = 1'b0;
    repeat (4) @(posedge clk); #1;

    // flush with a pop already in flight
    do_push(1'b0, 64'hD0, 1'b1);
    do_push(1'b0, 64'hD1, 1'b1);
    do_pop(1'b0, 64'hD0, 1'b1);
    bus.FLUSH = 2'b01;
    bus.W_VALID = 1'b1; bus.W_CH = 1'b0; bus.W_DATA = 64'hD9;
    bus.RD_REQ = 1'b1; bus.RD_CH = 1'b0;
    @(negedge clk);
    chk("w_ready_flushing", 64'(bus.W_READY), 64'd0);
    chk("rd_ack_flushing", 64'(bus.RD_ACK), 64'd0);
    @(posedge clk); #1;
    bus.W_CH = 1'b1; bus.W_DATA = 64'hE0;
    @(negedge clk);
    chk("w_ready_other_ch", 64'(bus.W_READY), 64'd1);
    @(posedge clk); #1;
    bus.FLUSH = '0; bus.W_VALID = 1'b0; bus.RD_REQ = 1'b0;
    chk("level_ch0_flushed", 64'(lvl(0)), 64'd0);
    chk("level_ch1_after_flush", 64'(lvl(1)), 64'd1);
    chk("empty_after_flush", 64'(bus.EMPTY), 64'b01);
    do_push(1'b0, 64'hD5, 1'b1);
    do_pop(1'b0, 64'hD5, 1'b1);
    do_pop(1'b1, 64'hE0, 1'b1);
    repeat (4) @(posedge clk); #1;

    // full ch0, simultaneous push+pop, then reset mid-pop
    for (int i = 0; i < 4; i++) do_push(1'b0, 64'hF0 + 64'(i), 1'b1);
    bus.R_READY = 1'b0;
    bus.W_VALID = 1'b1; bus.W_CH = 1'b0; bus.W_DATA = 64'hF4;
    bus.RD_REQ = 1'b1; bus.RD_CH = 1'b0;
    @(negedge clk);
    chk("w_ready_full_simul", 64'(bus.W_READY), 64'd0);
    chk("rd_ack_full_simul", 64'(bus.RD_ACK), 64'd1);
    @(posedge clk); #1;
    bus.W_VALID = 1'b0;
    chk("level_ch0_simul", 64'(lvl(0)), 64'd3);
    @(negedge clk);
    chk("rd_ack_second", 64'(bus.RD_ACK), 64'd1);
    @(posedge clk); #1;
    bus.RD_REQ = 1'b0;
    chk("r_valid_before_reset", 64'(bus.R_VALID), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("r_valid_in_reset", 64'(bus.R_VALID), 64'd0);
    chk("empty_in_reset", 64'(bus.EMPTY), 64'b11);
    chk("level_in_reset", 64'(bus.LEVEL), 64'd0);
    sb.delete();
    @(negedge clk) rst_n = 1'b1;
    bus.R_READY = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("r_valid_after_reset", 64'(bus.R_VALID), 64'd0);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
